// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding, shift
// direction select and opcode-class helpers.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SLL = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SK_SLL = 2'b00,
    SK_SRL = 2'b10,
    SK_SRA = 2'b11
  } shift_kind_t;

  function automatic logic is_shift(input logic [5:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
  endfunction

  function automatic shift_kind_t shift_kind(input logic [5:0] op);
    case (op)
      OP_SRL:  return SK_SRL;
      OP_SRA:  return SK_SRA;
      default: return SK_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle of the sequential ALU, plus a read-only view of the FSM state.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_CODE     = 6,
  parameter int NB_DATA_OUT = NB_DATA + 1
) ();

  // Both channels use plain valid/ready: a transfer happens on a rising clock
  // edge where valid and ready are both high; a source holds valid and its data
  // stable until that edge, and ready never depends combinationally on valid.
  logic                   i_valid;
  logic                   o_ready;
  logic [NB_DATA-1:0]     i_a;
  logic [NB_DATA-1:0]     i_b;
  logic [NB_CODE-1:0]     i_op;
  logic                   o_valid;
  logic                   i_ready;
  logic [NB_DATA_OUT-1:0] o_r;
  logic                   o_zero;
  logic                   o_neg;
  logic                   o_ovf;
  logic                   o_err;
  state_t                 dbg_state;

  modport slave (
    input  i_valid, i_a, i_b, i_op, i_ready,
    output o_ready, o_valid, o_r, o_zero, o_neg, o_ovf, o_err, dbg_state
  );

  modport master (
    output i_valid, i_a, i_b, i_op, i_ready,
    input  o_ready, o_valid, o_r, o_zero, o_neg, o_ovf, o_err, dbg_state
  );

endinterface

// File: rtl/alu_shift_step.sv
// One-bit shift of an NB_DATA word: logical left, logical right or arithmetic right.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8
) (
  input  logic [NB_DATA-1:0] din,
  input  shift_kind_t        kind,
  output logic [NB_DATA-1:0] dout
);

  always_comb begin
    dout = '0;
    case (kind)
      SK_SRL:  dout = {1'b0, din[NB_DATA-1:1]};
      SK_SRA:  dout = {din[NB_DATA-1], din[NB_DATA-1:1]};
      default: dout = {din[NB_DATA-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential handshaked ALU: single-cycle logic/arith ops, iterative 1 bit/cycle shifts.
// Define ALU_FLAGS_EN to build the zero/negative/overflow flag logic; otherwise flags read 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int NB_DATA     = 8,
  parameter int NB_CODE     = 6,
  parameter int NB_DATA_OUT = NB_DATA + 1
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  alu_seq_if.slave  bus
);

  localparam int CW  = $clog2(NB_DATA + 1);
  localparam int MSB = NB_DATA - 1;

  state_t                 state_q;
  logic                   ready_q;
  logic                   valid_q;
  logic [NB_DATA_OUT-1:0] r_q;
  logic                   err_q;
  logic [NB_DATA-1:0]     sh_q;
  logic [CW-1:0]          cnt_q;
  shift_kind_t            kind_q;

  logic [5:0]             op6;
  logic                   op_fits;
  logic [CW-1:0]          n_in;
  logic                   accept;
  logic                   go_shift;
  logic                   shifting;
  logic [NB_DATA-1:0]     step_out;
  logic [NB_DATA_OUT-1:0] alu_res;
  logic                   alu_err;
  logic [NB_DATA_OUT-1:0] fin_res;
  logic                   fin_err;
  logic                   load_fin;

  // Opcodes wider than 6 bits are legal only when the extra high bits are zero.
  assign op6      = 6'(bus.i_op);
  assign op_fits  = (NB_CODE'(op6) == bus.i_op);
  assign n_in     = (bus.i_b >= NB_DATA'(NB_DATA)) ? CW'(NB_DATA) : CW'(bus.i_b);
  assign accept   = (state_q == ST_IDLE) && bus.i_valid;
  assign go_shift = op_fits && is_shift(op6) && (n_in != '0);
  assign shifting = (state_q == ST_EXEC) || (state_q == ST_SHIFT);

  alu_shift_step #(.NB_DATA(NB_DATA)) u_step (
    .din  (sh_q),
    .kind (kind_q),
    .dout (step_out)
  );

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    if (!op_fits) begin
      alu_err = 1'b1;
    end else begin
      case (op6)
        OP_ADD:  alu_res = {1'b0, bus.i_a} + {1'b0, bus.i_b};
        OP_SUB:  alu_res = {1'b0, bus.i_a} - {1'b0, bus.i_b};
        OP_AND:  alu_res = {1'b0, bus.i_a & bus.i_b};
        OP_OR:   alu_res = {1'b0, bus.i_a | bus.i_b};
        OP_XOR:  alu_res = {1'b0, bus.i_a ^ bus.i_b};
        OP_NOR:  alu_res = {1'b0, ~(bus.i_a | bus.i_b)};
        OP_SRL, OP_SRA, OP_SLL: alu_res = {1'b0, bus.i_a};
        default: alu_err = 1'b1;
      endcase
    end
  end

  // The final result comes either straight from the inputs (accept) or from the last shift step.
  assign fin_res  = shifting ? {1'b0, step_out} : alu_res;
  assign fin_err  = shifting ? 1'b0 : alu_err;
  assign load_fin = (accept && !go_shift) || (shifting && (cnt_q == CW'(1)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      r_q     <= '0;
      err_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      kind_q  <= SK_SLL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (go_shift) begin
              state_q <= ST_EXEC;
              sh_q    <= bus.i_a;
              cnt_q   <= n_in;
              kind_q  <= shift_kind(op6);
            end else begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
              r_q     <= fin_res;
              err_q   <= fin_err;
            end
          end
        end
        // EXEC is the first shift cycle; SHIFT carries on until the count runs out.
        ST_EXEC, ST_SHIFT: begin
          sh_q  <= step_out;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
            r_q     <= fin_res;
            err_q   <= fin_err;
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic zero_q;
  logic neg_q;
  logic ovf_q;
  logic ovf_nxt;

  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
  always_comb begin
    ovf_nxt = 1'b0;
    if ((state_q == ST_IDLE) && op_fits) begin
      case (op6)
        OP_ADD: ovf_nxt = (bus.i_a[MSB] == bus.i_b[MSB]) && (alu_res[MSB] != bus.i_a[MSB]);
        OP_SUB: ovf_nxt = (bus.i_a[MSB] != bus.i_b[MSB]) && (alu_res[MSB] != bus.i_a[MSB]);
        default: ovf_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load_fin) begin
      zero_q <= !fin_err && (fin_res[MSB:0] == '0);
      neg_q  <= !fin_err && fin_res[MSB];
      ovf_q  <= ovf_nxt;
    end
  end

  assign bus.o_zero = zero_q;
  assign bus.o_neg  = neg_q;
  assign bus.o_ovf  = ovf_q;
`else
  assign bus.o_zero = 1'b0;
  assign bus.o_neg  = 1'b0;
  assign bus.o_ovf  = 1'b0;
`endif

  assign bus.o_ready   = ready_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_r       = r_q;
  assign bus.o_err     = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: scoreboard of expected results and latencies,
// checked by an independent monitor whenever o_valid rises.
module tb_alu_seq;
  import alu_pkg::*;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  localparam int W = 13;  // {err, ovf, neg, zero, r[8:0]}

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   seen   = 1'b0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           acc_q[$];

  alu_seq_if #(.NB_DATA(8), .NB_CODE(6), .NB_DATA_OUT(9)) bus ();

  alu_seq #(.NB_DATA(8), .NB_CODE(6), .NB_DATA_OUT(9)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic [8:0] r, input logic z, input logic n,
                                            input logic o, input logic e);
    return {e, FLAGS_EN & o, FLAGS_EN & n, FLAGS_EN & z, r};
  endfunction

  // driver
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                       input logic [W-1:0] exp, input int lat, input bit push);
    int k;
    @(negedge clk);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_op    = op;
    bus.i_valid = 1'b1;
    k = 0;
    while (!bus.o_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", {31'd0, bus.o_ready}, 32'd1);
    if (bus.o_ready && push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_a     = 8'($urandom_range(0, 255));
    bus.i_b     = 8'($urandom_range(0, 255));
    bus.i_op    = 6'($urandom_range(0, 63));
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    lat_q.delete();
    acc_q.delete();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    int           t;
    int           l;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (bus.o_valid && !seen) begin
      seen = 1'b1;
      act  = {bus.o_err, bus.o_ovf, bus.o_neg, bus.o_zero, bus.o_r};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        t = acc_q.pop_front();
        check("result", 32'(act), 32'(e));
        check("latency", cyc - t + 1, l);
      end
    end else if (!bus.o_valid) begin
      seen = 1'b0;
    end
  end

  initial begin
    int k;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_op    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    check("rst_r",     {23'd0, bus.o_r}, 32'd0);
    check("rst_flags", {28'd0, bus.o_err, bus.o_ovf, bus.o_neg, bus.o_zero}, 32'd0);

    //            a      b      op             r       z     n     o     e     lat
    issue(8'hFF, 8'h01, OP_ADD, pack_exp(9'h100, 1'b1, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    issue(8'h80, 8'h01, OP_SUB, pack_exp(9'h07F, 1'b0, 1'b0, 1'b1, 1'b0), 1, 1'b1);
    issue(8'h00, 8'h01, OP_SUB, pack_exp(9'h1FF, 1'b0, 1'b1, 1'b0, 1'b0), 1, 1'b1);
    issue(8'h7F, 8'h01, OP_ADD, pack_exp(9'h080, 1'b0, 1'b1, 1'b1, 1'b0), 1, 1'b1);
    issue(8'hF0, 8'h3C, OP_AND, pack_exp(9'h030, 1'b0, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    issue(8'hF0, 8'h0C, OP_OR,  pack_exp(9'h0FC, 1'b0, 1'b1, 1'b0, 1'b0), 1, 1'b1);
    issue(8'hFF, 8'h0F, OP_XOR, pack_exp(9'h0F0, 1'b0, 1'b1, 1'b0, 1'b0), 1, 1'b1);
    issue(8'h0F, 8'hF0, OP_NOR, pack_exp(9'h000, 1'b1, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    issue(8'h90, 8'd3,  OP_SRA, pack_exp(9'h0F2, 1'b0, 1'b1, 1'b0, 1'b0), 4, 1'b1);
    issue(8'h90, 8'd200, OP_SRL, pack_exp(9'h000, 1'b1, 1'b0, 1'b0, 1'b0), 9, 1'b1);
    issue(8'h81, 8'd1,  OP_SLL, pack_exp(9'h002, 1'b0, 1'b0, 1'b0, 1'b0), 2, 1'b1);
    issue(8'h55, 8'd0,  OP_SRL, pack_exp(9'h055, 1'b0, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    issue(8'h90, 8'd8,  OP_SRA, pack_exp(9'h0FF, 1'b0, 1'b1, 1'b0, 1'b0), 9, 1'b1);
    issue(8'h12, 8'h34, 6'b111111, pack_exp(9'h000, 1'b0, 1'b0, 1'b0, 1'b1), 1, 1'b1);
    wait_drain();

    // backpressure: result must hold and new requests must be refused
    bus.i_ready = 1'b0;
    issue(8'h12, 8'h34, OP_ADD, pack_exp(9'h046, 1'b0, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    k = 0;
    while (!bus.o_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    bus.i_a     = 8'h01;
    bus.i_b     = 8'h01;
    bus.i_op    = OP_ADD;
    bus.i_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, bus.o_valid}, 32'd1);
      check("bp_ready", {31'd0, bus.o_ready}, 32'd0);
      check("bp_r",     {23'd0, bus.o_r}, 32'h046);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", {31'd0, bus.o_valid}, 32'd0);
    check("bp_release_ready", {31'd0, bus.o_ready}, 32'd1);
    wait_drain();
    issue(8'h20, 8'h05, OP_SUB, pack_exp(9'h01B, 1'b0, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    wait_drain();

    // asynchronous reset in the middle of a shift
    issue(8'h01, 8'd7, OP_SLL, '0, 8, 1'b0);
    repeat (2) @(negedge clk);
    check("mid_shift_state", 32'(bus.dbg_state), 32'(ST_SHIFT));
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, bus.o_valid}, 32'd0);
    check("abort_r",     {23'd0, bus.o_r}, 32'd0);
    check("abort_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h03, 8'h04, OP_ADD, pack_exp(9'h007, 1'b0, 1'b0, 1'b0, 1'b0), 1, 1'b1);
    wait_drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
